// File: rtl/alu_pkg.sv
// Shared definitions for the ALU shift stage: op encodings, output-buffer
// states and the shift-amount width helper.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_RSVD = 2'b11
    } aluOp_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_FULL  = 2'b01,
        BUF_SKID  = 2'b10
    } bufState_e;

    // Bits of the shift operand needed to address every bit of a dataWidth word.
    function automatic int unsigned shamtWidth(input int unsigned dataWidth);
        return $clog2(dataWidth);
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry output buffer (main + skid register). Ready and valid are decoded
// from registered state only, so downstream ready never reaches upstream ready.
module skid_buffer
    import alu_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 70
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inValid,
    output logic                     outReady,
    input  logic [PAYLOAD_WIDTH-1:0] inData,
    output logic                     outValid,
    input  logic                     inReady,
    output logic [PAYLOAD_WIDTH-1:0] outData
);

    bufState_e                state_r;
    bufState_e                stateNext_s;
    logic [PAYLOAD_WIDTH-1:0] mainReg_r;
    logic [PAYLOAD_WIDTH-1:0] skidReg_r;
    logic                     accept_s;
    logic                     deliver_s;
    logic                     loadMain_s;
    logic                     loadSkid_s;
    logic                     moveSkid_s;

    assign outValid  = (state_r != BUF_EMPTY);
    assign outReady  = (state_r != BUF_SKID);
    assign outData   = mainReg_r;
    assign accept_s  = inValid & outReady;
    assign deliver_s = outValid & inReady;

    // Next-state and register-load decode.
    always_comb begin
        stateNext_s = state_r;
        loadMain_s  = 1'b0;
        loadSkid_s  = 1'b0;
        moveSkid_s  = 1'b0;
        case (state_r)
            BUF_EMPTY: begin
                if (accept_s) begin
                    stateNext_s = BUF_FULL;
                    loadMain_s  = 1'b1;
                end else begin
                    stateNext_s = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (accept_s && deliver_s) begin
                    loadMain_s = 1'b1;
                end else if (accept_s) begin
                    stateNext_s = BUF_SKID;
                    loadSkid_s  = 1'b1;
                end else if (deliver_s) begin
                    stateNext_s = BUF_EMPTY;
                end else begin
                    stateNext_s = BUF_FULL;
                end
            end
            BUF_SKID: begin
                if (deliver_s) begin
                    stateNext_s = BUF_FULL;
                    moveSkid_s  = 1'b1;
                end else begin
                    stateNext_s = BUF_SKID;
                end
            end
            default: begin
                stateNext_s = BUF_EMPTY;
            end
        endcase
    end

    // State register; reset drops any buffered ops immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BUF_EMPTY;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Main register feeds the outputs; refilled from upstream or from skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainReg_r <= '0;
        end else if (loadMain_s) begin
            mainReg_r <= inData;
        end else if (moveSkid_s) begin
            mainReg_r <= skidReg_r;
        end
    end

    // Skid register catches the op accepted while the main entry is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skidReg_r <= '0;
        end else if (loadSkid_s) begin
            skidReg_r <= inData;
        end
    end

endmodule

// File: rtl/alu_shift_stage.sv
// Shift execution stage: computes SLL/SRL/SRA (and 32-bit word forms) at
// accept time and hands the result, tag and illegal flag to a skid buffer.
module alu_shift_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_numA,
    input  logic [DATA_WIDTH-1:0] in_numB,
    input  logic [1:0]            in_op,
    input  logic                  in_word,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_illegal
);

    localparam int SHAMT_W       = shamtWidth(DATA_WIDTH);
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH + 1;

    logic [SHAMT_W-1:0]       shamt_s;
    logic [4:0]               shamtWord_s;
    logic [DATA_WIDTH-1:0]    fullRes_s;
    logic [31:0]              wordRes_s;
    logic [DATA_WIDTH-1:0]    result_s;
    logic                     illegal_s;
    logic [PAYLOAD_WIDTH-1:0] inPayload_s;
    logic [PAYLOAD_WIDTH-1:0] outPayload_s;
    logic                     unusedBits_s;

    assign shamt_s      = in_numB[SHAMT_W-1:0];
    assign shamtWord_s  = in_numB[4:0];
    assign unusedBits_s = ^in_numB[DATA_WIDTH-1:SHAMT_W];

    // Shift datapath; word forms work on the low 32 bits and sign-extend bit 31.
    always_comb begin
        fullRes_s = '0;
        wordRes_s = 32'h0000_0000;
        illegal_s = 1'b0;
        case (in_op)
            OP_SLL: begin
                fullRes_s = in_numA << shamt_s;
                wordRes_s = in_numA[31:0] << shamtWord_s;
            end
            OP_SRL: begin
                fullRes_s = in_numA >> shamt_s;
                wordRes_s = in_numA[31:0] >> shamtWord_s;
            end
            OP_SRA: begin
                fullRes_s = $signed(in_numA) >>> shamt_s;
                wordRes_s = $signed(in_numA[31:0]) >>> shamtWord_s;
            end
            OP_RSVD: begin
                illegal_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
        if (illegal_s) begin
            result_s = '0;
        end else if (in_word) begin
            result_s = {{(DATA_WIDTH-32){wordRes_s[31]}}, wordRes_s};
        end else begin
            result_s = fullRes_s;
        end
    end

    assign inPayload_s = {illegal_s, in_tag, result_s};

    skid_buffer #(
        .PAYLOAD_WIDTH(PAYLOAD_WIDTH)
    ) u_skid_buffer (
        .clk     (in_clk),
        .rst_n   (in_rst_n),
        .inValid (in_valid),
        .outReady(out_ready),
        .inData  (inPayload_s),
        .outValid(out_valid),
        .inReady (in_ready),
        .outData (outPayload_s)
    );

    assign out_result  = outPayload_s[DATA_WIDTH-1:0];
    assign out_tag     = outPayload_s[DATA_WIDTH +: TAG_WIDTH];
    assign out_illegal = outPayload_s[PAYLOAD_WIDTH-1];

endmodule

// File: tb/tb_alu_shift_stage.sv
// Directed-vector bench for alu_shift_stage: shift results, word forms,
// reserved op, skid back-pressure ordering and asynchronous reset in SKID.
module tb_alu_shift_stage;

    logic        in_clk;
    logic        in_rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_numA;
    logic [63:0] in_numB;
    logic [1:0]  in_op;
    logic        in_word;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        in_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int checkCnt = 0;
    int passCnt  = 0;

    alu_shift_stage #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut (
        .in_clk     (in_clk),
        .in_rst_n   (in_rst_n),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .in_numA    (in_numA),
        .in_numB    (in_numB),
        .in_op      (in_op),
        .in_word    (in_word),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_illegal(out_illegal)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        if (obs === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic driveOp(input logic [1:0] op, input logic word, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_word  = word;
        in_numA  = a;
        in_numB  = b;
        in_tag   = tag;
    endtask

    // Present one op at a negedge, let the posedge accept it, check at the next negedge.
    task automatic runOp(input string name, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                         input logic [63:0] expRes, input logic expIll);
        driveOp(op, word, a, b, tag);
        @(negedge in_clk);
        in_valid = 1'b0;
        checkEq({name, "_valid"}, 64'(out_valid), 64'd1);
        checkEq({name, "_result"}, out_result, expRes);
        checkEq({name, "_tag"}, 64'(out_tag), 64'(tag));
        checkEq({name, "_illegal"}, 64'(out_illegal), 64'(expIll));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        in_rst_n = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b1;
        driveOp(2'b00, 1'b0, 64'd0, 64'd0, 5'd0);
        in_valid = 1'b0;
        #12;
        checkEq("rst_valid", 64'(out_valid), 64'd0);
        checkEq("rst_ready", 64'(out_ready), 64'd1);
        checkEq("rst_result", out_result, 64'd0);
        checkEq("rst_tag", 64'(out_tag), 64'd0);
        checkEq("rst_illegal", 64'(out_illegal), 64'd0);
        @(negedge in_clk);
        in_rst_n = 1'b1;

        // Back-to-back ops with downstream always ready.
        runOp("sll63",  2'b00, 1'b0, 64'h1, 64'd63, 5'd1, 64'h8000_0000_0000_0000, 1'b0);
        runOp("sraw4",  2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 5'd2, 64'hFFFF_FFFF_F800_0000, 1'b0);
        runOp("srlmask", 2'b01, 1'b0, 64'hF000_0000_0000_0000, 64'h44, 5'd3, 64'h0F00_0000_0000_0000, 1'b0);
        runOp("sllwmask", 2'b00, 1'b1, 64'h1, 64'h21, 5'd4, 64'h2, 1'b0);
        runOp("sra63",  2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'h3F, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        runOp("srlw31", 2'b01, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd31, 5'd6, 64'h1, 1'b0);
        runOp("sllwsext", 2'b00, 1'b1, 64'h4000_0000, 64'd1, 5'd8, 64'hFFFF_FFFF_8000_0000, 1'b0);
        runOp("rsvd",   2'b11, 1'b0, 64'hDEAD, 64'd0, 5'd7, 64'h0, 1'b1);
        runOp("legal",  2'b00, 1'b0, 64'h3, 64'd0, 5'd9, 64'h3, 1'b0);
        @(negedge in_clk);
        checkEq("drain_valid", 64'(out_valid), 64'd0);

        // Back-pressure: fill main and skid, hold a third op upstream.
        in_ready = 1'b0;
        driveOp(2'b00, 1'b0, 64'd1, 64'd0, 5'd1);
        @(negedge in_clk);
        driveOp(2'b00, 1'b0, 64'd2, 64'd0, 5'd2);
        @(negedge in_clk);
        checkEq("skid_valid", 64'(out_valid), 64'd1);
        checkEq("skid_ready", 64'(out_ready), 64'd0);
        checkEq("skid_tag", 64'(out_tag), 64'd1);
        driveOp(2'b00, 1'b0, 64'd3, 64'd0, 5'd3);
        @(negedge in_clk);
        checkEq("hold_ready", 64'(out_ready), 64'd0);
        checkEq("hold_tag", 64'(out_tag), 64'd1);
        checkEq("hold_result", out_result, 64'd1);
        in_ready = 1'b1;
        @(negedge in_clk);
        checkEq("order_tag2", 64'(out_tag), 64'd2);
        checkEq("order_res2", out_result, 64'd2);
        checkEq("order_valid2", 64'(out_valid), 64'd1);
        @(negedge in_clk);
        in_valid = 1'b0;
        checkEq("order_tag3", 64'(out_tag), 64'd3);
        checkEq("order_valid3", 64'(out_valid), 64'd1);
        @(negedge in_clk);
        checkEq("order_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset while in SKID.
        in_ready = 1'b0;
        driveOp(2'b00, 1'b0, 64'h11, 64'd0, 5'd11);
        @(negedge in_clk);
        driveOp(2'b00, 1'b0, 64'h12, 64'd0, 5'd12);
        @(negedge in_clk);
        in_valid = 1'b0;
        checkEq("pre_rst_ready", 64'(out_ready), 64'd0);
        #2;
        in_rst_n = 1'b0;
        #1;
        checkEq("arst_valid", 64'(out_valid), 64'd0);
        checkEq("arst_ready", 64'(out_ready), 64'd1);
        checkEq("arst_result", out_result, 64'd0);
        checkEq("arst_tag", 64'(out_tag), 64'd0);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        in_ready = 1'b1;
        runOp("post_rst", 2'b01, 1'b0, 64'h100, 64'd4, 5'd13, 64'h10, 1'b0);
        @(negedge in_clk);
        checkEq("post_rst_empty", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
